// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle sequencer and the 8-bit CPU datapath.
// The master side is the controller; the slave side is the datapath/board.
interface multicycle_ctrl_if;
   logic       en;
   logic [5:0] OP;
   logic [5:0] Funct;
   logic       Zero;
   logic       PCWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic       IorD;
   logic       MemtoReg;
   logic       RegDst;
   logic       ULASrcA;
   logic [1:0] ULASrcB;
   logic [1:0] PCSrc;
   logic [2:0] ULAControl;
   logic       IllegalOp;
   logic [3:0] State;

   modport master (
      input  en, OP, Funct, Zero,
      output PCWrite, IRWrite, RegWrite, MemWrite, IorD, MemtoReg, RegDst,
             ULASrcA, ULASrcB, PCSrc, ULAControl, IllegalOp, State
   );

   modport slave (
      output en, OP, Funct, Zero,
      input  PCWrite, IRWrite, RegWrite, MemWrite, IorD, MemtoReg, RegDst,
             ULASrcA, ULASrcB, PCSrc, ULAControl, IllegalOp, State
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multicycle 8-bit CPU: decodes OP/Funct, drives datapath
// selects and strobes, and stretches FETCH/MEMREAD by MEM_WAIT cycles for synchronous memory.
module multicycle_ctrl #(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXEC     = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEX   = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_J      = 6'b000010;

   state_t     state;
   logic [2:0] wait_cnt;
   logic       illegal_q;
   logic       mem_done;
   logic       go;
   logic       funct_ok;
   logic [2:0] funct_alu;

   assign mem_done = (wait_cnt == WAIT_LAST);
   // Strobes only fire on an advancing cycle and never while reset is held.
   assign go       = bus.en & ~rst;

   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = 3'b010;
      case (bus.Funct)
         6'b100000: funct_alu = 3'b010;
         6'b100010: funct_alu = 3'b110;
         6'b100100: funct_alu = 3'b000;
         6'b100101: funct_alu = 3'b001;
         6'b101010: funct_alu = 3'b111;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         wait_cnt  <= '0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         if (bus.en) begin
            case (state)
               DECODE: begin
                  case (bus.OP)
                     OP_LW, OP_SW: state <= MEMADR;
                     OP_RTYPE:     state <= EXEC;
                     OP_BEQ:       state <= BRANCH;
                     OP_ADDI:      state <= ADDIEX;
                     OP_J:         state <= JUMP;
                     default: begin
                        state     <= FETCH;
                        illegal_q <= 1'b1;
                     end
                  endcase
               end
               MEMADR:  state <= (bus.OP == OP_SW) ? MEMWRITE : MEMREAD;
               MEMREAD: begin
                  if (mem_done) begin
                     state    <= MEMWB;
                     wait_cnt <= '0;
                  end else begin
                     wait_cnt <= wait_cnt + 3'd1;
                  end
               end
               EXEC: begin
                  if (funct_ok) begin
                     state <= ALUWB;
                  end else begin
                     state     <= FETCH;
                     illegal_q <= 1'b1;
                  end
               end
               ADDIEX:  state <= ADDIWB;
               MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP: state <= FETCH;
               // FETCH, plus the unused codes 12-15 which behave as FETCH.
               default: begin
                  if (mem_done) begin
                     state    <= DECODE;
                     wait_cnt <= '0;
                  end else begin
                     wait_cnt <= wait_cnt + 3'd1;
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      bus.PCWrite    = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IorD       = 1'b0;
      bus.MemtoReg   = 1'b0;
      bus.RegDst     = 1'b0;
      bus.ULASrcA    = 1'b0;
      bus.ULASrcB    = 2'b00;
      bus.PCSrc      = 2'b00;
      bus.ULAControl = 3'b010;
      case (state)
         DECODE:   bus.ULASrcB = 2'b10;
         MEMADR: begin
            bus.ULASrcA = 1'b1;
            bus.ULASrcB = 2'b10;
         end
         MEMREAD:  bus.IorD = 1'b1;
         MEMWB: begin
            bus.MemtoReg = 1'b1;
            bus.RegWrite = go;
         end
         MEMWRITE: begin
            bus.IorD     = 1'b1;
            bus.MemWrite = go;
         end
         EXEC: begin
            bus.ULASrcA    = 1'b1;
            bus.ULAControl = funct_alu;
         end
         ALUWB: begin
            bus.RegDst   = 1'b1;
            bus.RegWrite = go;
         end
         BRANCH: begin
            bus.ULASrcA    = 1'b1;
            bus.ULAControl = 3'b110;
            bus.PCSrc      = 2'b01;
            bus.PCWrite    = go & bus.Zero;
         end
         ADDIEX: begin
            bus.ULASrcA = 1'b1;
            bus.ULASrcB = 2'b10;
         end
         ADDIWB:   bus.RegWrite = go;
         JUMP: begin
            bus.PCSrc   = 2'b10;
            bus.PCWrite = go;
         end
         default: begin
            bus.ULASrcB = 2'b01;
            bus.IRWrite = go & mem_done;
            bus.PCWrite = go & mem_done;
         end
      endcase
   end

   assign bus.IllegalOp = illegal_q;
   assign bus.State     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: two instances (MEM_WAIT=1 and 2) checked
// against a per-instruction state-sequence model built from the instruction lengths.
module tb_multicycle_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multicycle_ctrl_if b1 ();
   multicycle_ctrl_if b2 ();

   multicycle_ctrl #(.MEM_WAIT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
   multicycle_ctrl #(.MEM_WAIT(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
   localparam logic [19:0] STROBE_MASK = 20'h0F000;

   int n_cmp = 0;
   int n_bad = 0;
   int en_pct = 100;
   bit pend1 = 1'b0;
   bit pend2 = 1'b0;
   int q[$];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] obs(int sel);
      if (sel == 1)
         return {b1.State, b1.PCWrite, b1.IRWrite, b1.RegWrite, b1.MemWrite, b1.IorD,
                 b1.MemtoReg, b1.RegDst, b1.ULASrcA, b1.ULASrcB, b1.PCSrc, b1.ULAControl,
                 b1.IllegalOp};
      return {b2.State, b2.PCWrite, b2.IRWrite, b2.RegWrite, b2.MemWrite, b2.IorD,
              b2.MemtoReg, b2.RegDst, b2.ULASrcA, b2.ULASrcB, b2.PCSrc, b2.ULAControl,
              b2.IllegalOp};
   endfunction

   function automatic bit op_ok(logic [5:0] op);
      return op inside {LW, SW, RT, BEQ, ADDI, JMP};
   endfunction

   // {legal, ALU code} for an R-type Funct field
   function automatic logic [3:0] fn_info(logic [5:0] fn);
      case (fn)
         6'b100000: return 4'b1010;
         6'b100010: return 4'b1110;
         6'b100100: return 4'b1000;
         6'b100101: return 4'b1001;
         6'b101010: return 4'b1111;
         default:   return 4'b0010;
      endcase
   endfunction

   function automatic logic [19:0] exp_vec(int code, bit go, bit last, bit zero,
                                           logic [5:0] fn, bit ill);
      logic pcw = 0, irw = 0, rw = 0, mw = 0, iord = 0, m2r = 0, rd = 0, sa = 0;
      logic [1:0] sb = 2'b00, ps = 2'b00;
      logic [2:0] alu = 3'b010;
      logic [3:0] fi;
      fi = fn_info(fn);
      case (code)
         0:  begin sb = 2'b01; pcw = go & last; irw = go & last; end
         1:  sb = 2'b10;
         2:  begin sa = 1; sb = 2'b10; end
         3:  iord = 1;
         4:  begin m2r = 1; rw = go; end
         5:  begin iord = 1; mw = go; end
         6:  begin sa = 1; alu = fi[2:0]; end
         7:  begin rd = 1; rw = go; end
         8:  begin sa = 1; alu = 3'b110; ps = 2'b01; pcw = go & zero; end
         9:  begin sa = 1; sb = 2'b10; end
         10: rw = go;
         11: begin ps = 2'b10; pcw = go; end
         default: ;
      endcase
      return {4'(code), pcw, irw, rw, mw, iord, m2r, rd, sa, sb, ps, alu, ill};
   endfunction

   task automatic set_en(int sel, bit e);
      if (sel == 1) b1.en = e;
      else          b2.en = e;
   endtask

   task automatic do_reset(int n);
      repeat (n) begin
         rst   = 1'b1;
         b1.en = 1'($urandom_range(0, 1));
         b2.en = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("rst_strobes_u1", 32'(obs(1) & STROBE_MASK), 32'd0);
         chk("rst_strobes_u2", 32'(obs(2) & STROBE_MASK), 32'd0);
         @(posedge clk); #1;
      end
      rst   = 1'b0;
      pend1 = 1'b0;
      pend2 = 1'b0;
   endtask

   task automatic run_instr(int sel, logic [5:0] op, logic [5:0] fn, bit z, int abort);
      int w = (sel == 1) ? 1 : 2;
      int cyc = 0;
      int code;
      bit e, last, ill, nxt;
      logic [3:0] fi;
      fi = fn_info(fn);
      b1.OP = op; b2.OP = op; b1.Funct = fn; b2.Funct = fn; b1.Zero = z; b2.Zero = z;
      q.delete();
      repeat (w + 1) q.push_back(0);
      q.push_back(1);
      if (op_ok(op)) begin
         case (op)
            LW:   begin q.push_back(2); repeat (w + 1) q.push_back(3); q.push_back(4); end
            SW:   begin q.push_back(2); q.push_back(5); end
            RT:   begin q.push_back(6); if (fi[3]) q.push_back(7); end
            BEQ:  q.push_back(8);
            ADDI: begin q.push_back(9); q.push_back(10); end
            default: q.push_back(11);
         endcase
      end
      while (q.size() > 0 && cyc < 400 && !(abort > 0 && cyc >= abort)) begin
         e = ($urandom_range(0, 99) < en_pct);
         set_en(sel, e);
         set_en(3 - sel, 1'b0);
         @(negedge clk);
         code = q[0];
         last = (q.size() > 1) && (q[1] != 0);
         ill  = (sel == 1) ? pend1 : pend2;
         chk($sformatf("u%0d_state%0d_op%02h_fn%02h_en%0d", sel, code, op, fn, e),
             32'(obs(sel)), 32'(exp_vec(code, e, last, z, fn, ill)));
         @(posedge clk); #1;
         nxt = e && ((code == 1 && !op_ok(op)) || (code == 6 && !fi[3]));
         if (sel == 1) begin pend1 = nxt; pend2 = 1'b0; end
         else          begin pend2 = nxt; pend1 = 1'b0; end
         if (e) void'(q.pop_front());
         cyc++;
      end
      if (abort > 0 && q.size() > 0)
         do_reset($urandom_range(1, 2));
      else if (q.size() > 0)
         chk("timeout", 32'(q.size()), 32'd0);
   endtask

   initial begin
      logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [5:0] op, fn;
      int k;
      b1.en = 1'b1; b2.en = 1'b1;
      b1.OP = '0; b2.OP = '0; b1.Funct = '0; b2.Funct = '0; b1.Zero = 1'b0; b2.Zero = 1'b0;
      do_reset(2);

      en_pct = 100;
      run_instr(1, RT, 6'b100000, 1'b0, 0);
      run_instr(2, LW, 6'b000000, 1'b0, 0);
      run_instr(1, BEQ, 6'b000000, 1'b1, 0);
      run_instr(1, BEQ, 6'b000000, 1'b0, 0);
      run_instr(2, ADDI, 6'b000000, 1'b0, 0);
      run_instr(2, JMP, 6'b000000, 1'b0, 0);
      en_pct = 50;
      run_instr(2, SW, 6'b000000, 1'b0, 0);
      run_instr(1, SW, 6'b000000, 1'b0, 0);
      en_pct = 100;
      run_instr(1, 6'b111111, 6'b000000, 1'b0, 0);
      run_instr(1, RT, 6'b000111, 1'b0, 0);
      run_instr(1, RT, 6'b101010, 1'b0, 0);

      en_pct = 70;
      for (int i = 0; i < 120; i++) begin
         k  = $urandom_range(0, 7);
         fn = legal_fn[$urandom_range(0, 4)];
         case (k)
            0: op = LW;
            1: op = SW;
            2: op = RT;
            3: op = BEQ;
            4: op = ADDI;
            5: op = JMP;
            6: begin op = RT; fn = 6'($urandom); end
            default: op = 6'($urandom);
         endcase
         run_instr($urandom_range(1, 2), op, fn, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0);
      end
      run_instr(1, RT, 6'b100100, 1'b0, 0);
      run_instr(2, RT, 6'b100101, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
